// File: rtl/bus_grant_arbiter.sv
// Two-requester round-robin arbiter driving the one-hot ack select of the shared bus mux.
// Bounded hold time via MAX_HOLD and a mandatory one-cycle dead (TURN) cycle between owners.
module bus_grant_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] ack,
  output logic       busy,
  output logic       owner,
  output logic       preempt
);

  localparam bit             LIMIT_EN  = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT1 = 2'd1,
    S_GNT2 = 2'd2,
    S_TURN = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic               r_last;
  logic [1:0]         r_ack;
  logic               r_busy;
  logic               r_owner;
  logic               r_preempt;

  state_t             w_state_nxt;
  state_t             w_pick;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_last_nxt;
  logic               w_preempt_nxt;
  logic               w_own;
  logic               w_oth;
  logic               w_timeout;
  logic [1:0]         w_ack_nxt;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_last     <= 1'b1;
      r_ack      <= 2'b00;
      r_busy     <= 1'b0;
      r_owner    <= 1'b0;
      r_preempt  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_cnt_nxt;
      r_last     <= w_last_nxt;
      r_ack      <= w_ack_nxt;
      r_busy     <= |w_ack_nxt;
      r_owner    <= w_ack_nxt[1];
      r_preempt  <= w_preempt_nxt;
    end
  end

  // Next-state, hold counter and output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_hold_cnt;
    w_last_nxt    = r_last;
    w_preempt_nxt = 1'b0;
    w_pick        = S_IDLE;
    w_own         = (r_state == S_GNT2);
    w_oth         = ~w_own;
    w_timeout     = LIMIT_EN && (r_hold_cnt == HOLD_LAST);

    // r_last=1 means requester 2 was served last, so requester 1 wins a tie
    unique case (req)
      2'b01:   w_pick = S_GNT1;
      2'b10:   w_pick = S_GNT2;
      2'b11:   w_pick = r_last ? S_GNT1 : S_GNT2;
      default: w_pick = S_IDLE;
    endcase

    unique case (r_state)
      S_IDLE, S_TURN: begin
        w_state_nxt = w_pick;
        w_cnt_nxt   = '0;
      end
      S_GNT1, S_GNT2: begin
        if (!req[w_own]) begin
          w_state_nxt = S_TURN;
          w_last_nxt  = w_own;
          w_cnt_nxt   = '0;
        end else if (w_timeout && req[w_oth]) begin
          w_state_nxt   = S_TURN;
          w_last_nxt    = w_own;
          w_cnt_nxt     = '0;
          w_preempt_nxt = 1'b1;
        end else if (w_timeout) begin
          w_cnt_nxt = '0;
        end else if (r_hold_cnt != '1) begin
          w_cnt_nxt = r_hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_ack_nxt = {w_state_nxt == S_GNT2, w_state_nxt == S_GNT1};
  end

  assign ack     = r_ack;
  assign busy    = r_busy;
  assign owner   = r_owner;
  assign preempt = r_preempt;

endmodule
